// File: rtl/counter_pkg.sv
// Shared constants for the counter slice.
package counter_pkg;

    localparam int unsigned COUNTER_WIDTH_DEFAULT = 16;

endpackage

// File: rtl/counter_if.sv
// Control/status bundle for a counter instance: the master drives control, the slave reports the count.
interface counter_if
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = COUNTER_WIDTH_DEFAULT
);
    logic             reset;
    logic             enable;
    logic [WIDTH-1:0] count;
    logic             wrap;

    modport master (output reset, output enable, input count, input wrap);
    modport slave  (input reset, input enable, output count, output wrap);
endinterface

// File: rtl/counter.sv
// Enable-gated binary up-counter with a registered one-cycle wrap pulse.
module counter
    import counter_pkg::*;
#(
    parameter int unsigned COUNTER_WIDTH = COUNTER_WIDTH_DEFAULT
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     i_enable,
    output logic [COUNTER_WIDTH-1:0] o_counter,
    output logic                     o_wrap
);

    // One extra bit so the carry-out of the increment becomes the wrap flag.
    logic [COUNTER_WIDTH:0] sum;

    always_comb begin
        sum = {1'b0, o_counter} + (COUNTER_WIDTH + 1)'(1);
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_counter <= '0;
            o_wrap    <= 1'b0;
        end else if (i_enable) begin
            o_counter <= sum[COUNTER_WIDTH-1:0];
            o_wrap    <= sum[COUNTER_WIDTH];
        end else begin
            o_wrap    <= 1'b0;
        end
    end

    // Simulation-only checks; seen_reset masks the undefined pre-reset state.
    logic seen_reset;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            seen_reset <= 1'b1;
        end
    end

    a_advance : assert property (@(posedge i_clock)
        ($past(seen_reset) && !$past(i_reset) && $past(i_enable))
        |-> (o_counter == COUNTER_WIDTH'($past(o_counter) + 1'b1)));

    a_stable : assert property (@(posedge i_clock)
        ($past(seen_reset) && !$past(i_reset) && !$past(i_enable))
        |-> (o_counter == $past(o_counter)));

    generate
        if (COUNTER_WIDTH > 1) begin : g_wrap_chk
            a_wrap_single : assert property (@(posedge i_clock)
                (seen_reset && o_wrap) |=> !o_wrap);
        end
    endgenerate

endmodule

// File: tb/tb_counter.sv
// Scoreboard bench for counter: a 16-bit and a 3-bit instance, directed stimulus with hand-computed milestones.
module tb_counter;

    typedef struct {
        logic [63:0] cnt;
        logic        wrap;
        string       nm;
    } exp_t;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    counter_if #(.WIDTH(16)) bus16 ();
    counter_if #(.WIDTH(3))  bus3  ();

    counter #(.COUNTER_WIDTH(16)) u_wide (
        .i_clock  (clk),
        .i_reset  (bus16.reset),
        .i_enable (bus16.enable),
        .o_counter(bus16.count),
        .o_wrap   (bus16.wrap)
    );

    counter #(.COUNTER_WIDTH(3)) u_narrow (
        .i_clock  (clk),
        .i_reset  (bus3.reset),
        .i_enable (bus3.enable),
        .o_counter(bus3.count),
        .o_wrap   (bus3.wrap)
    );

    exp_t q16[$];
    exp_t q3[$];
    int   checks = 0;
    int   passed = 0;

    // Reference state of each instance, used between hand-computed milestones.
    logic [15:0] m16;
    logic        mw16;
    logic [2:0]  m3;
    logic        mw3;

    task automatic compare(input string nm, input logic [63:0] act_c, input logic act_w,
                           input logic [63:0] exp_c, input logic exp_w);
        checks++;
        if (act_c !== exp_c || act_w !== exp_w) begin
            $display("FAIL %s: got counter=%0h wrap=%0b, expected counter=%0h wrap=%0b",
                     nm, act_c, act_w, exp_c, exp_w);
        end else begin
            passed++;
        end
    endtask

    // Monitor: one output sample per clock edge for every queued expectation.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q16.size() > 0) begin
            e = q16.pop_front();
            compare(e.nm, 64'(bus16.count), bus16.wrap, e.cnt, e.wrap);
        end
        if (q3.size() > 0) begin
            e = q3.pop_front();
            compare(e.nm, 64'(bus3.count), bus3.wrap, e.cnt, e.wrap);
        end
    end

    task automatic step16(input logic rst, input logic en, input logic hand,
                          input logic [15:0] hc, input logic hw, input string nm);
        exp_t e;
        @(negedge clk);
        bus16.reset  = rst;
        bus16.enable = en;
        if (rst) begin
            m16 = '0; mw16 = 1'b0;
        end else if (en) begin
            mw16 = (m16 == 16'hFFFF);
            m16  = m16 + 16'd1;
        end else begin
            mw16 = 1'b0;
        end
        e.cnt  = hand ? 64'(hc) : 64'(m16);
        e.wrap = hand ? hw : mw16;
        e.nm   = nm;
        q16.push_back(e);
    endtask

    task automatic step3(input logic rst, input logic en, input logic hand,
                         input logic [2:0] hc, input logic hw, input string nm);
        exp_t e;
        @(negedge clk);
        bus3.reset  = rst;
        bus3.enable = en;
        if (rst) begin
            m3 = '0; mw3 = 1'b0;
        end else if (en) begin
            mw3 = (m3 == 3'd7);
            m3  = m3 + 3'd1;
        end else begin
            mw3 = 1'b0;
        end
        e.cnt  = hand ? 64'(hc) : 64'(m3);
        e.wrap = hand ? hw : mw3;
        e.nm   = nm;
        q3.push_back(e);
    endtask

    logic [2:0] seq3 [9];
    logic       wseq3[9];

    initial begin
        bus16.reset = 1'b1; bus16.enable = 1'b0;
        bus3.reset  = 1'b1; bus3.enable  = 1'b0;
        seq3  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1};
        wseq3 = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

        // Reset with enable low, then idle.
        step16(1'b1, 1'b0, 1'b1, 16'd0, 1'b0, "reset");
        step16(1'b0, 1'b0, 1'b1, 16'd0, 1'b0, "reset_idle");
        step16(1'b0, 1'b0, 1'b1, 16'd0, 1'b0, "reset_idle");

        for (int unsigned i = 1; i <= 375; i++)
            step16(1'b0, 1'b1, i == 375, 16'h0177, 1'b0, "count375");
        for (int unsigned i = 0; i < 5; i++)
            step16(1'b0, 1'b0, 1'b1, 16'd375, 1'b0, "hold375");

        for (int unsigned i = 1; i <= 750; i++)
            step16(1'b0, 1'b1, i == 750, 16'd1125, 1'b0, "resume1125");
        step16(1'b0, 1'b0, 1'b1, 16'd1125, 1'b0, "hold1125");

        // Full-range wrap at 16 bits.
        step16(1'b1, 1'b0, 1'b1, 16'd0, 1'b0, "reset_wrap");
        for (int unsigned i = 1; i <= 65535; i++)
            step16(1'b0, 1'b1, i == 65535, 16'hFFFF, 1'b0, "count_ffff");
        step16(1'b0, 1'b1, 1'b1, 16'h0000, 1'b1, "wrap_pulse");
        step16(1'b0, 1'b1, 1'b1, 16'h0001, 1'b0, "after_wrap");
        step16(1'b0, 1'b0, 1'b1, 16'h0001, 1'b0, "idle_after_wrap");

        // Reset wins over enable mid-count.
        step16(1'b1, 1'b0, 1'b1, 16'd0, 1'b0, "reset_prio_setup");
        for (int unsigned i = 1; i <= 16'h1234; i++)
            step16(1'b0, 1'b1, i == 16'h1234, 16'h1234, 1'b0, "count1234");
        step16(1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, "reset_prio");
        step16(1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, "reset_held_en");
        step16(1'b0, 1'b1, 1'b1, 16'h0001, 1'b0, "post_reset_count");
        step16(1'b0, 1'b0, 1'b1, 16'h0001, 1'b0, "post_reset_hold");

        // Narrow width wrap sequence.
        step3(1'b1, 1'b0, 1'b1, 3'd0, 1'b0, "n_reset");
        for (int unsigned i = 0; i < 9; i++)
            step3(1'b0, 1'b1, 1'b1, seq3[i], wseq3[i], "n_seq");
        step3(1'b0, 1'b0, 1'b1, 3'd1, 1'b0, "n_hold");
        step3(1'b0, 1'b0, 1'b1, 3'd1, 1'b0, "n_hold");

        // Drain the scoreboard with a bounded wait.
        for (int unsigned i = 0; i < 10 && (q16.size() > 0 || q3.size() > 0); i++)
            @(negedge clk);
        if (q16.size() > 0 || q3.size() > 0) begin
            checks++;
            $display("FAIL drain: got %0d entries left, expected 0", q16.size() + q3.size());
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #(64'd20 * 64'd200000);
        $display("FAIL timeout: got no completion, expected finish within 200000 cycles");
        $fatal(1, "timeout");
    end

endmodule
